single_filter_conv: RTL and testbench

// - Single-filter 2-D valid convolution in IEEE-754 single precision (FP32) for the CNN datapath.
// - Convolves a 10x10 FP32 image with one 5x5 FP32 kernel and produces a 6x6 FP32 feature map.
// - One multiply-accumulate (MAC) per clock, using in-block FP32 multiply and add units.

---
 rtl/single_filter_conv.sv | 202 ++++++++++++++++++++
 tb/tb_single_filter_conv.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/single_filter_conv.sv
// FP32 2-D valid convolution of an IMG x IMG image with one K x K kernel,
// one multiply-accumulate per clock, raster output order, taps k = i*K + j.
module single_filter_conv #(
  parameter int IMG = 10,
  parameter int K   = 5,
  parameter int DW  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DW*IMG*IMG-1:0]     image,
  input  logic [DW*K*K-1:0]         filter,
  output logic [DW*(IMG-K+1)*(IMG-K+1)-1:0] conv_image,
  output logic                      busy,
  output logic                      done
);

  localparam int OUT = IMG - K + 1;
  localparam int KW  = $clog2(K);
  localparam int CW  = $clog2(OUT);
  localparam int PBW = $clog2(DW*IMG*IMG);
  localparam int TBW = $clog2(DW*K*K);
  localparam int OBW = $clog2(DW*OUT*OUT);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                  state_q;
  logic [DW*IMG*IMG-1:0]   img_q;
  logic [DW*K*K-1:0]       flt_q;
  logic [DW*OUT*OUT-1:0]   conv_q;
  logic [DW-1:0]           acc_q, acc_d, acc_in, prod, pix, tap;
  logic [CW-1:0]           r_q, c_q;
  logic [KW-1:0]           i_q, j_q;
  logic                    busy_q, done_q;
  logic [PBW-1:0]          pix_base;
  logic [TBW-1:0]          tap_base;
  logic [OBW-1:0]          out_base;
  logic                    tap_last, out_last;

  // Denormals read as signed zero, truncating rounding, underflow -> +0.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, s;
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    logic [31:0] res;
    a_nan  = (&a[30:23]) & (|a[22:0]);
    a_inf  = (&a[30:23]) & ~(|a[22:0]);
    a_zero = ~(|a[30:23]);
    b_nan  = (&b[30:23]) & (|b[22:0]);
    b_inf  = (&b[30:23]) & ~(|b[22:0]);
    b_zero = ~(|b[30:23]);
    s      = a[31] ^ b[31];
    p      = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e      = {2'b00, a[30:23]} + {2'b00, b[30:23]} + {9'd0, p[47]};
    m      = p[47] ? p[46:24] : p[45:23];
    if (a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf)) res = QNAN;
    else if (a_inf | b_inf)                                   res = {s, 8'hFF, 23'd0};
    else if (a_zero | b_zero)                                 res = {s, 31'd0};
    else if (e >= 10'd382)                                    res = {s, 8'hFF, 23'd0};
    else if (e <= 10'd127)                                    res = '0;
    else                                                      res = {s, 8'(e - 10'd127), m};
    return res;
  endfunction

  // Three guard bits with sticky keep truncation exact for both add and subtract.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, swap, lost, found;
    logic [31:0] big, sml, res;
    logic [7:0]  d;
    logic [26:0] fb, fs, mask, diff, dn, sn;
    logic [27:0] sum;
    logic [8:0]  ex;
    logic [4:0]  lz;
    a_nan  = (&a[30:23]) & (|a[22:0]);
    a_inf  = (&a[30:23]) & ~(|a[22:0]);
    a_zero = ~(|a[30:23]);
    b_nan  = (&b[30:23]) & (|b[22:0]);
    b_inf  = (&b[30:23]) & ~(|b[22:0]);
    b_zero = ~(|b[30:23]);
    swap   = b[30:0] > a[30:0];
    big    = swap ? b : a;
    sml    = swap ? a : b;
    d      = big[30:23] - sml[30:23];
    fb     = {1'b1, big[22:0], 3'b000};
    fs     = {1'b1, sml[22:0], 3'b000};
    mask   = ~(27'h7FF_FFFF << d);
    lost   = |(fs & mask);
    fs     = (fs >> d) | {26'd0, lost};
    sum    = {1'b0, fb} + {1'b0, fs};
    diff   = fb - fs;
    lz     = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < 27; k++) begin
      if (!found && diff[26-k]) begin
        lz    = 5'(k);
        found = 1'b1;
      end
    end
    dn = diff << lz;
    if (sum[27]) begin
      sn = sum[27:1] | {26'd0, sum[0]};
      ex = {1'b0, big[30:23]} + 9'd1;
    end else begin
      sn = sum[26:0];
      ex = {1'b0, big[30:23]};
    end
    if (a_nan | b_nan | (a_inf & b_inf & (a[31] ^ b[31]))) res = QNAN;
    else if (a_inf)               res = {a[31], 8'hFF, 23'd0};
    else if (b_inf)               res = {b[31], 8'hFF, 23'd0};
    else if (a_zero & b_zero)     res = {a[31] & b[31], 31'd0};
    else if (a_zero)              res = b;
    else if (b_zero)              res = a;
    else if (big[31] == sml[31]) begin
      if (ex[8] | (&ex[7:0]))     res = {big[31], 8'hFF, 23'd0};
      else                        res = {big[31], ex[7:0], sn[25:3]};
    end
    else if (diff == '0)          res = '0;
    else if ({1'b0, big[30:23]} <= {4'd0, lz}) res = '0;
    else                          res = {big[31], big[30:23] - {3'd0, lz}, dn[25:3]};
    return res;
  endfunction

  always_comb begin
    pix_base = (PBW'(r_q) + PBW'(i_q)) * PBW'(IMG*DW) + (PBW'(c_q) + PBW'(j_q)) * PBW'(DW);
    tap_base = TBW'(i_q) * TBW'(K*DW) + TBW'(j_q) * TBW'(DW);
    out_base = OBW'(r_q) * OBW'(OUT*DW) + OBW'(c_q) * OBW'(DW);
    pix      = img_q[pix_base +: DW];
    tap      = flt_q[tap_base +: DW];
    tap_last = (i_q == KW'(K-1)) && (j_q == KW'(K-1));
    out_last = (r_q == CW'(OUT-1)) && (c_q == CW'(OUT-1));
    acc_in   = ((i_q == '0) && (j_q == '0)) ? '0 : acc_q;
    prod     = fp_mul(pix, tap);
    acc_d    = fp_add(acc_in, prod);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      conv_q  <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
      c_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            img_q   <= image;
            flt_q   <= filter;
            r_q     <= '0;
            c_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (tap_last) begin
            conv_q[out_base +: DW] <= acc_d;
            i_q <= '0;
            j_q <= '0;
            if (out_last) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else if (c_q == CW'(OUT-1)) begin
              c_q <= '0;
              r_q <= r_q + CW'(1);
            end else begin
              c_q <= c_q + CW'(1);
            end
          end else begin
            acc_q <= acc_d;
            if (j_q == KW'(K-1)) begin
              j_q <= '0;
              i_q <= i_q + KW'(1);
            end else begin
              j_q <= j_q + KW'(1);
            end
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign conv_image = conv_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_single_filter_conv.sv
// Bench for single_filter_conv: table of image/filter/expected-map vectors fed
// through a scoreboard queue, plus abort, restart and ignored-start sequences.
module tb_single_filter_conv;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [3199:0] image;
  logic [799:0]  filter;
  logic [1151:0] conv_image;
  logic          busy, done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3199:0] img;
    logic [799:0]  flt;
    logic [1151:0] expv;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] val;
  } sb_t;

  localparam int NV = 9;
  vec_t vecs[NV];
  sb_t  sbq[$];

  single_filter_conv #(.IMG(10), .K(5), .DW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .image(image), .filter(filter),
    .conv_image(conv_image), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fp_of_int(input int n);
    int unsigned m;
    int          p;
    if (n == 0) return 32'd0;
    m = (n < 0) ? -n : n;
    p = 0;
    for (int b = 0; b < 24; b++) if (m[b]) p = b;
    return {n < 0, 8'(127 + p), 23'((m << (23 - p)) & 32'h7F_FFFF)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic run_conv(input int vi, input bit disturb);
    int  cyc;
    sb_t e;
    image  = vecs[vi].img;
    filter = vecs[vi].flt;
    start  = 1'b1;
    for (int k = 0; k < 36; k++) begin
      e.idx = k;
      e.val = vecs[vi].expv[32*k +: 32];
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    chk($sformatf("v%0d busy_after_start", vi), 32'(busy), 32'd1);
    while (!done && cyc < 1200) begin
      @(posedge clk); #1;
      cyc++;
      if (disturb && cyc == 300) begin
        image  = ~image;
        filter = {25{32'hBF800000}};
        start  = 1'b1;
      end
      if (disturb && cyc == 301) start = 1'b0;
    end
    // Start-sampling edge counts as edge 1.
    chk($sformatf("v%0d done_edge", vi), cyc, 32'd901);
    chk($sformatf("v%0d busy_at_done", vi), 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d done_pulse_end", vi), 32'(done), 32'd0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk($sformatf("v%0d out%0d", vi, e.idx), conv_image[32*e.idx +: 32], e.val);
    end
  endtask

  initial begin
    int seen;
    for (int v = 0; v < NV; v++) begin
      vecs[v].img  = '0;
      vecs[v].flt  = '0;
      vecs[v].expv = '0;
    end
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 10; c++) begin
        vecs[0].img[32*(r*10+c) +: 32] = 32'h40800000;
        vecs[1].img[32*(r*10+c) +: 32] = 32'h40000000;
        vecs[2].img[32*(r*10+c) +: 32] = fp_of_int(r*10 + c);
        vecs[3].img[32*(r*10+c) +: 32] = (r == 0 && c == 0) ? 32'h7F800001 : 32'h0;
        vecs[4].img[32*(r*10+c) +: 32] = fp_of_int((r*3 + c) % 5 - 2);
        vecs[5].img[32*(r*10+c) +: 32] = 32'h7F000000;
        vecs[6].img[32*(r*10+c) +: 32] = 32'h00800000;
        vecs[7].img[32*(r*10+c) +: 32] = (r == 0 && c == 0) ? 32'h7F800000 : 32'h3F800000;
        vecs[8].img[32*(r*10+c) +: 32] = (c % 2 == 0) ? 32'h3F800000 : 32'hB0800000;
      end
    end
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        vecs[0].flt[32*(i*5+j) +: 32] = 32'h3F800000;
        vecs[1].flt[32*(i*5+j) +: 32] = 32'hBF800000;
        vecs[2].flt[32*(i*5+j) +: 32] = (i == 2 && j == 2) ? 32'h3F800000 : 32'h0;
        vecs[3].flt[32*(i*5+j) +: 32] = 32'h3F800000;
        vecs[4].flt[32*(i*5+j) +: 32] = fp_of_int((i + 2*j) % 3 - 1);
        vecs[5].flt[32*(i*5+j) +: 32] = 32'hC0000000;
        vecs[6].flt[32*(i*5+j) +: 32] = 32'hBF000000;
        vecs[7].flt[32*(i*5+j) +: 32] = (i == 2 && j == 2) ? 32'h3F800000 : 32'h0;
        vecs[8].flt[32*(i*5+j) +: 32] = (i == 0 && j < 2) ? 32'h3F800000 : 32'h0;
      end
    end
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        int s;
        s = 0;
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            s += (((r+i)*3 + (c+j)) % 5 - 2) * ((i + 2*j) % 3 - 1);
        vecs[0].expv[32*(r*6+c) +: 32] = 32'h42C80000;
        vecs[1].expv[32*(r*6+c) +: 32] = 32'hC2480000;
        vecs[2].expv[32*(r*6+c) +: 32] = fp_of_int((r+2)*10 + c + 2);
        vecs[3].expv[32*(r*6+c) +: 32] = (r == 0 && c == 0) ? 32'h7FC00000 : 32'h0;
        vecs[4].expv[32*(r*6+c) +: 32] = fp_of_int(s);
        vecs[5].expv[32*(r*6+c) +: 32] = 32'hFF800000;
        vecs[6].expv[32*(r*6+c) +: 32] = 32'h0;
        vecs[7].expv[32*(r*6+c) +: 32] = (r == 0 && c == 0) ? 32'h7FC00000 : 32'h3F800000;
        vecs[8].expv[32*(r*6+c) +: 32] = 32'h3F7FFFFF;
      end
    end

    rst    = 1'b1;
    start  = 1'b0;
    image  = '0;
    filter = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    for (int k = 0; k < 36; k++) chk($sformatf("reset out%0d", k), conv_image[32*k +: 32], 32'h0);
    rst = 1'b0;

    for (int v = 0; v < NV; v++) run_conv(v, 1'b0);

    // Re-pulsed start and changed inputs mid-run must not disturb the run.
    run_conv(0, 1'b1);

    // Abort at cycle 400 of a run, then a clean restart.
    image  = vecs[2].img;
    filter = vecs[2].flt;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (399) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    for (int k = 0; k < 36; k++) chk($sformatf("abort out%0d", k), conv_image[32*k +: 32], 32'h0);
    seen = 0;
    repeat (950) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    chk("abort no_done", seen, 32'd0);
    run_conv(1, 1'b0);

    // start together with rst: reset wins.
    image  = vecs[0].img;
    filter = vecs[0].flt;
    rst    = 1'b1;
    start  = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_vs_start busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vs_start idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
